// File: rtl/reg_mem_sequencer.sv
// reg_mem_sequencer
// Transfers a block of registers V0..Vx between the register file and memory.
// A store (dir=0) writes V0..Vx to memory. A load (dir=1) reads memory into
// V0..Vx. The block of memory starts at base_addr.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   start           begin one transfer (sampled only in IDLE)
//   dir             0 = store registers to memory, 1 = load memory to registers
//   last_reg        index of the last register transferred (inclusive)
//   base_addr       memory address of V0
//   busy, done      transfer in progress / one-cycle completion pulse
//   i_next          base_addr + last_reg + 1 of the last completed transfer
//   rf_*            register file address, write strobe, write and read data
//   mem_*           memory request handshake: req is held until ack
module reg_mem_sequencer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [3:0]        last_reg,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] i_next,
    output logic [3:0]        rf_address,
    output logic              rf_write,
    output logic [7:0]        rf_write_data,
    input  logic [7:0]        rf_read_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              dir_q, dir_d;
    logic [3:0]        last_q, last_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0] i_next_q, i_next_d;
    logic [ADDR_W-1:0] end_addr;
    logic              at_last;

    // Address just past the block; the addition wraps at 2^ADDR_W.
    assign end_addr = base_q + ADDR_W'(last_q) + ADDR_W'(1);
    assign at_last  = (idx_q == last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            dir_q    <= 1'b0;
            last_q   <= '0;
            base_q   <= '0;
            rdata_q  <= '0;
            i_next_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            last_q   <= last_d;
            base_q   <= base_d;
            rdata_q  <= rdata_d;
            i_next_q <= i_next_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        last_d   = last_q;
        base_d   = base_q;
        rdata_d  = rdata_q;
        i_next_d = i_next_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    last_d  = last_reg;
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (mem_ack) begin
                    if (dir_q) begin
                        rdata_d = mem_rdata;
                        state_d = WB;
                    end else if (at_last) begin
                        i_next_d = end_addr;
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            WB: begin
                if (at_last) begin
                    i_next_d = end_addr;
                    state_d  = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = XFER;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        rf_address    = '0;
        rf_write      = 1'b0;
        rf_write_data = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        case (state_q)
            XFER: begin
                busy       = 1'b1;
                mem_req    = 1'b1;
                mem_we     = ~dir_q;
                mem_addr   = base_q + ADDR_W'(idx_q);
                rf_address = idx_q;
                if (!dir_q) begin
                    mem_wdata = rf_read_data;
                end
            end
            WB: begin
                busy          = 1'b1;
                rf_write      = 1'b1;
                rf_address    = idx_q;
                rf_write_data = rdata_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign i_next = i_next_q;

endmodule

// File: tb/tb_reg_mem_sequencer.sv
module tb_reg_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic [3:0]  last_reg;
    logic [11:0] base_addr;
    logic        busy;
    logic        done;
    logic [11:0] i_next;
    logic [3:0]  rf_address;
    logic        rf_write;
    logic [7:0]  rf_write_data;
    logic [7:0]  rf_read_data;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    reg_mem_sequencer #(.ADDR_W(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dir           (dir),
        .last_reg      (last_reg),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .i_next        (i_next),
        .rf_address    (rf_address),
        .rf_write      (rf_write),
        .rf_write_data (rf_write_data),
        .rf_read_data  (rf_read_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack)
    );

    always #5 clk = ~clk;

    // Environment: register file and memory contents owned by the bench.
    logic [7:0] rf_m  [16];
    logic [7:0] mem_m [4096];
    assign rf_read_data = rf_m[rf_address];

    // Expected transactions, in order, for the transfer in progress.
    typedef struct {
        int unsigned idx;
        int unsigned addr;
        bit          we;
        int unsigned data;
    } acc_t;
    typedef struct {
        int unsigned idx;
        int unsigned data;
    } wr_t;

    acc_t acc_q[$];
    wr_t  wr_q[$];
    int unsigned exp_inext;
    int unsigned exp_busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned busy_cnt = 0;
    int unsigned last_busy = 0;
    int unsigned done_cnt = 0;
    int unsigned rfw_cnt = 0;
    int unsigned lat_cfg = 0;
    int unsigned wait_cnt = 0;
    bit          junk_ack = 1'b0;
    bit          prev_done = 1'b0;
    bit          prev_wait = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory responder: ack after lat_cfg wait cycles; stray acks while idle.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req) begin
            if (wait_cnt >= lat_cfg) begin
                mem_ack   = 1'b1;
                wait_cnt  = 0;
                mem_rdata = mem_m[mem_addr];
            end else begin
                mem_ack   = 1'b0;
                wait_cnt++;
                mem_rdata = 8'($urandom);
            end
        end else begin
            wait_cnt  = 0;
            mem_ack   = junk_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = 8'($urandom);
        end
    end

    // Compare process: checks every cycle against the expected transaction lists.
    acc_t ca;
    wr_t  cw;
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            wr_q.delete();
            busy_cnt  = 0;
            prev_done = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_done) chk("done_width", {31'b0, done}, 32'd0);
            prev_done = done;
            if (prev_wait) chk("req_held", {31'b0, mem_req}, 32'd1);
            prev_wait = mem_req && !mem_ack;
            if (mem_req) begin
                chk("req_busy", {31'b0, busy}, 32'd1);
                if (acc_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    ca = acc_q[0];
                    chk("mem_addr", {20'b0, mem_addr}, ca.addr);
                    chk("mem_we", {31'b0, mem_we}, {31'b0, ca.we});
                    chk("rf_addr_xfer", {28'b0, rf_address}, ca.idx);
                    if (ca.we) chk("mem_wdata", {24'b0, mem_wdata}, ca.data);
                    if (mem_ack) begin
                        if (mem_we) mem_m[mem_addr] = mem_wdata;
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (rf_write) begin
                chk("wb_no_req", {31'b0, mem_req}, 32'd0);
                if (wr_q.size() == 0) begin
                    chk("unexpected_rf_write", 32'd1, 32'd0);
                end else begin
                    cw = wr_q.pop_front();
                    chk("rf_wr_addr", {28'b0, rf_address}, cw.idx);
                    chk("rf_wr_data", {24'b0, rf_write_data}, cw.data);
                    rf_m[rf_address] = rf_write_data;
                    rfw_cnt++;
                end
            end
            if (!busy) begin
                chk("idle_req", {31'b0, mem_req}, 32'd0);
                chk("idle_rfw", {31'b0, rf_write}, 32'd0);
                chk("idle_rfa", {28'b0, rf_address}, 32'd0);
                chk("idle_maddr", {20'b0, mem_addr}, 32'd0);
                chk("idle_wdata", {24'b0, mem_wdata}, 32'd0);
                chk("idle_rfwd", {24'b0, rf_write_data}, 32'd0);
            end
            if (done) begin
                chk("done_busy", {31'b0, busy}, 32'd0);
                chk("i_next", {20'b0, i_next}, exp_inext);
                chk("busy_cycles", busy_cnt, exp_busy);
                chk("acc_left", acc_q.size(), 32'd0);
                chk("wr_left", wr_q.size(), 32'd0);
                last_busy = busy_cnt;
                busy_cnt  = 0;
                done_cnt++;
            end
        end
    end

    task automatic push_expect(input bit d, input int unsigned x, input int unsigned base,
                               input int unsigned lat);
        acc_t a;
        wr_t  w;
        for (int unsigned i = 0; i <= x; i++) begin
            a.idx  = i;
            a.addr = (base + i) % 4096;
            a.we   = !d;
            a.data = d ? 0 : rf_m[i];
            acc_q.push_back(a);
            if (d) begin
                w.idx  = i;
                w.data = mem_m[(base + i) % 4096];
                wr_q.push_back(w);
            end
        end
        exp_inext = (base + x + 1) % 4096;
        exp_busy  = (x + 1) * (lat + 1) + (d ? x + 1 : 0);
        lat_cfg   = lat;
    endtask

    task automatic launch(input bit d, input int unsigned x, input int unsigned base);
        dir       = d;
        last_reg  = x[3:0];
        base_addr = base[11:0];
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        dir       = 1'($urandom);
        last_reg  = 4'($urandom);
        base_addr = 12'($urandom);
    endtask

    task automatic run_xfer(input bit d, input int unsigned x, input int unsigned base,
                            input int unsigned lat, input bit mid);
        int unsigned c;
        push_expect(d, x, base, lat);
        launch(d, x, base);
        if (mid) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            dir   = !d;
            @(negedge clk);
            start = 1'b0;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 3000);
        chk("done_seen", {31'b0, done}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int unsigned c;
        int unsigned d0;
        rst       = 1'b0;
        start     = 1'b0;
        dir       = 1'b0;
        last_reg  = '0;
        base_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 4096; i++) mem_m[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rf_m[i] = 8'($urandom);

        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_rfw", {31'b0, rf_write}, 32'd0);
        chk("rst_inext", {20'b0, i_next}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Store of four registers, zero-wait ack.
        rf_m[0] = 8'h11; rf_m[1] = 8'h22; rf_m[2] = 8'h33; rf_m[3] = 8'h44;
        run_xfer(1'b0, 3, 'h300, 0, 1'b0);
        chk("st_m300", {24'b0, mem_m['h300]}, 32'h11);
        chk("st_m301", {24'b0, mem_m['h301]}, 32'h22);
        chk("st_m302", {24'b0, mem_m['h302]}, 32'h33);
        chk("st_m303", {24'b0, mem_m['h303]}, 32'h44);
        chk("st_inext", {20'b0, i_next}, 32'h304);
        chk("st_busy4", last_busy, 32'd4);

        // Load of two registers with two wait cycles per access.
        mem_m['h200] = 8'hAA;
        mem_m['h201] = 8'hBB;
        d0 = done_cnt;
        run_xfer(1'b1, 1, 'h200, 2, 1'b0);
        chk("ld_v0", {24'b0, rf_m[0]}, 32'hAA);
        chk("ld_v1", {24'b0, rf_m[1]}, 32'hBB);
        chk("ld_busy8", last_busy, 32'd8);
        chk("ld_done_once", done_cnt - d0, 32'd1);

        // Address wrap past the top of memory.
        run_xfer(1'b0, 2, 'hFFE, 0, 1'b0);
        chk("wr_inext", {20'b0, i_next}, 32'h001);
        chk("wr_m000", {24'b0, mem_m[0]}, {24'b0, rf_m[2]});
        chk("wr_mfff", {24'b0, mem_m['hFFF]}, {24'b0, rf_m[1]});

        // Full 16-register load with a start pulse during the transfer.
        junk_ack = 1'b1;
        d0 = rfw_cnt;
        run_xfer(1'b1, 15, 0, 0, 1'b1);
        chk("full_busy32", last_busy, 32'd32);
        chk("full_rfw16", rfw_cnt - d0, 32'd16);
        chk("full_inext", {20'b0, i_next}, 32'h010);

        // Reset in the write-back of register 2 during a six-register load.
        push_expect(1'b1, 5, 'h0A0, 1);
        launch(1'b1, 5, 'h0A0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(rf_write && rf_address == 4'd2) && c < 500);
        chk("wb2_reached", {31'b0, rf_write}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        chk("arst_rfw", {31'b0, rf_write}, 32'd0);
        chk("arst_rfa", {28'b0, rf_address}, 32'd0);
        chk("arst_rfwd", {24'b0, rf_write_data}, 32'd0);
        chk("arst_inext", {20'b0, i_next}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_xfer(1'b1, 5, 'h123, 0, 1'b0);

        // Randomized transfers with random wait states and stray acks.
        for (int n = 0; n < 30; n++) begin
            run_xfer(1'($urandom), $urandom_range(0, 15), $urandom_range(0, 4095),
                     $urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_mem_sequencer.md
REG_MEM_SEQUENCER -- requirements
Module: reg_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, default 12: memory address width in bits.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request one block transfer; sampled only in IDLE.
REQ-005 dir  in  1  0 = store V0..Vx to memory, 1 = load memory into V0..Vx.
REQ-006 last_reg  in  4  index x of the last register transferred (inclusive).
REQ-007 base_addr  in  ADDR_W  memory address for V0 (the index register I).
REQ-008 busy  out  1  high while a transfer is in progress.
REQ-009 done  out  1  one-cycle pulse when a transfer completes.
REQ-010 i_next  out  ADDR_W  base_addr + last_reg + 1, mod 2^ADDR_W, of the last completed transfer.
REQ-011 rf_address  out  4  register file address.
REQ-012 rf_write  out  1  register file write enable.
REQ-013 rf_write_data  out  8  register file write data.
REQ-014 rf_read_data  in  8  combinational register file read data at rf_address.
REQ-015 mem_req  out  1  memory request; held until mem_ack.
REQ-016 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-017 mem_addr  out  ADDR_W  memory address; valid while mem_req is high.
REQ-018 mem_wdata  out  8  write data; valid while mem_req and mem_we are high.
REQ-019 mem_rdata  in  8  read data; valid in the cycle mem_ack is high.
REQ-020 mem_ack  in  1  completes the pending request in the cycle it is high.

Function
REQ-021 States SHALL be IDLE, XFER, WB and DONE; a 4-bit index idx SHALL count the current register.
REQ-022 In IDLE, start=1 SHALL latch dir, last_reg and base_addr, clear idx to 0, and go to XFER.
REQ-023 In XFER, the block SHALL drive mem_req=1, mem_addr=(latched base + idx) mod 2^ADDR_W, rf_address=idx and mem_we=~dir.
REQ-024 In a store (dir=0), the block SHALL drive mem_wdata=rf_read_data combinationally while in XFER.
REQ-025 In XFER, mem_ack=0 SHALL hold all outputs and stay in XFER; the request is never withdrawn.
REQ-026 In a store, mem_ack=1 SHALL go to DONE if idx==latched last_reg, else increment idx and stay in XFER.
REQ-027 In a load, mem_ack=1 SHALL capture mem_rdata and go to WB.
REQ-028 In WB, the block SHALL drive rf_write=1, rf_address=idx and rf_write_data=captured byte, with mem_req=0.
REQ-029 From WB, the block SHALL go to DONE if idx==latched last_reg, else increment idx and return to XFER.
REQ-030 DONE SHALL last exactly one cycle: done=1, busy=0, i_next updated; then IDLE.
REQ-031 busy SHALL be 1 in XFER and WB and 0 in IDLE and DONE.
REQ-032 start SHALL be ignored outside IDLE; changes to dir, last_reg and base_addr during a transfer SHALL have no effect.
REQ-033 mem_ack outside XFER SHALL be ignored.
REQ-034 Outside XFER and WB: mem_req=0, rf_write=0, rf_address=0; mem_addr, mem_wdata and rf_write_data SHALL be 0 there.
REQ-035 Latency with zero-wait mem_ack: a store of N=x+1 registers SHALL take N XFER cycles, then DONE; a load SHALL take 2N cycles, then DONE.
REQ-036 A memory address that passes 2^ADDR_W-1 SHALL wrap to 0; i_next SHALL wrap the same way.
REQ-037 last_reg=0 SHALL transfer V0 only; last_reg=15 SHALL transfer all 16 registers without idx overflow.

Reset
REQ-038 rst=1 SHALL force IDLE at once, including mid-transfer: busy=0, done=0, mem_req=0, rf_write=0, idx=0, i_next=0 and the captured byte 0; a partial transfer is abandoned.

Verification
REQ-039 Store: base=0x300, x=3, V0..V3=11,22,33,44, ack tied high -> writes 0x300..0x303 = 11,22,33,44 in 4 cycles; done next cycle; i_next=0x304.
REQ-040 Load with 2-cycle ack latency: base=0x200, x=1, mem 0x200=AA, 0x201=BB -> V0=AA, V1=BB; mem_req held through each wait; done once.
REQ-041 Wrap: base=0xFFE, x=2, store -> addresses 0xFFE, 0xFFF, 0x000; i_next=0x001.
REQ-042 Full load x=15 -> 16 rf writes at addresses 0..15, 32 busy cycles with zero-wait ack; start pulsed mid-transfer is ignored.
REQ-043 rst asserted in WB of register 2 (x=5 load) -> outputs at reset values at once; later start runs a fresh transfer from idx 0.
